// File: rtl/piso_serializer_pkg.sv
// Shared types for the parallel-in/serial-out transmitter and its bit counter.
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_t;

  localparam int unsigned PISO_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake plus serial-side signals of the serializer, as one bundle.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);

  logic             load_valid;
  logic [WIDTH-1:0] data_in;
  logic             load_ready;
  logic             hold;
  logic             ser_out;
  logic             ser_en;
  logic             last;
  logic             busy;

  modport master (
    output load_valid, data_in, hold,
    input  load_ready, ser_out, ser_en, last, busy
  );

  modport slave (
    input  load_valid, data_in, hold,
    output load_ready, ser_out, ser_en, last, busy
  );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Mod-WIDTH bit counter with clear/increment/hold and a terminal flag at WIDTH-1.
module piso_bit_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_hold,
  output logic o_term
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;

  // Wraps only from the terminal value, so the count never exceeds WIDTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      if (i_clr || (i_inc && (r_cnt == LastCnt))) begin
        r_cnt <= '0;
      end else if (i_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_term = (r_cnt == LastCnt);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word on valid/ready and emits one
// strobed bit per non-held cycle, reloading back-to-back on the last bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit          LSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst,
  piso_serializer_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  piso_state_t      r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shifted;
  logic             w_busy;
  logic             w_term;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;

  assign w_busy   = (r_state == SHIFT);
  assign w_last   = w_busy && w_term && !bus.hold;
  // Ready on the last bit lets the next word follow with no bubble.
  assign w_ready  = !w_busy || w_last;
  assign w_accept = bus.load_valid && w_ready;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (!w_busy),
    .i_inc  (w_busy),
    .i_hold (w_busy && bus.hold),
    .o_term (w_term)
  );

  always_comb begin
    w_shifted = '0;
    if (LSB_FIRST) begin
      w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end else begin
      w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg <= bus.data_in;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!bus.hold) begin
            if (!w_term) begin
              r_shreg <= w_shifted;
            end else if (w_accept) begin
              r_shreg <= bus.data_in;
            end else begin
              r_shreg <= '0;
              r_state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign bus.load_ready = w_ready;
  assign bus.ser_out    = w_busy && (LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1]);
  assign bus.ser_en     = w_busy && !bus.hold;
  assign bus.last       = w_last;
  assign bus.busy       = w_busy;

endmodule
